// File: rtl/nco_note_sequencer.sv
// -----------------------------------------------------------------------------
// nco_note_sequencer
//   Step sequencer driving the control inputs of one NCO. A table of STEPS
//   entries (Q32.32 frequency, wave code, duty cycle, duration in ticks) is
//   written from the host port at any time and played back in order, either
//   once or looped. Each entry is held on the outputs for max(dur,1) ticks,
//   where one tick is DIV = CLK_FREQ/TICK_RATE clock cycles.
//
// Ports
//   clk           system clock (shared with the NCO)
//   rst_n         asynchronous active-low reset
//   wr_en_i       table write strobe
//   wr_addr_i     table write address (addresses >= STEPS are ignored)
//   wr_freq_i     entry frequency, Q32.32 Hz
//   wr_wave_i     entry wave code (0 SINE, 1 TRI, 2 SAW, 3 SQUARE)
//   wr_duty_i     entry duty cycle
//   wr_dur_i      entry duration in ticks (0 plays one tick)
//   start_i       pulse: begin playback at entry 0 (ignored while busy)
//   stop_i        pulse: abort playback, outputs go silent
//   loop_i        1 = wrap to entry 0 after the last step
//   last_step_i   index of the final entry, latched on an accepted start
//   frequency_o   NCO frequency
//   wave_o        NCO wave
//   duty_cycle_o  NCO duty cycle
//   step_idx_o    index of the entry currently on the outputs
//   step_strobe_o 1-cycle pulse when new entry values appear
//   busy_o        1 while fetching or playing
//   done_o        1-cycle pulse on normal (non-loop) completion
// -----------------------------------------------------------------------------
module nco_note_sequencer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_RATE = 1_000,
  parameter int BIT_DEPTH = 8,
  parameter int STEPS     = 16,
  parameter int ADDR_W    = 4,
  parameter int DUR_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en_i,
  input  logic [ADDR_W-1:0]    wr_addr_i,
  input  logic [63:0]          wr_freq_i,
  input  logic [1:0]           wr_wave_i,
  input  logic [BIT_DEPTH-1:0] wr_duty_i,
  input  logic [DUR_W-1:0]     wr_dur_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 loop_i,
  input  logic [ADDR_W-1:0]    last_step_i,
  output logic [63:0]          frequency_o,
  output logic [1:0]           wave_o,
  output logic [BIT_DEPTH-1:0] duty_cycle_o,
  output logic [ADDR_W-1:0]    step_idx_o,
  output logic                 step_strobe_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int DIV    = CLK_FREQ / TICK_RATE;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_MAX  = ADDR_W'(STEPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2
  } state_e;

  // Clamp a requested final index into the populated part of the table.
  function automatic logic [ADDR_W-1:0] clamp_last(input logic [ADDR_W-1:0] v);
    if (32'(v) >= 32'(STEPS)) begin
      return LAST_MAX;
    end else begin
      return v;
    end
  endfunction

  // Step table (not reset: contents must survive rst_n)
  logic [63:0]          freq_mem [DEPTH];
  logic [1:0]           wave_mem [DEPTH];
  logic [BIT_DEPTH-1:0] duty_mem [DEPTH];
  logic [DUR_W-1:0]     dur_mem  [DEPTH];

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]    last_q, last_d;
  logic [63:0]          freq_q, freq_d;
  logic [1:0]           wave_q, wave_d;
  logic [BIT_DEPTH-1:0] duty_q, duty_d;
  logic [ADDR_W-1:0]    step_idx_q, step_idx_d;
  logic [DUR_W-1:0]     dur_q, dur_d;
  logic [TICK_W-1:0]    tcnt_q, tcnt_d;
  logic [DUR_W-1:0]     dcnt_q, dcnt_d;
  logic                 strobe_q, strobe_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 tick_s;
  logic [DUR_W-1:0]     dur_last_s;

  // Host write port into the step table; writes are allowed in every state.
  always_ff @(posedge clk) begin
    if (wr_en_i && (32'(wr_addr_i) < 32'(STEPS))) begin
      freq_mem[wr_addr_i] <= wr_freq_i;
      wave_mem[wr_addr_i] <= wr_wave_i;
      duty_mem[wr_addr_i] <= wr_duty_i;
      dur_mem[wr_addr_i]  <= wr_dur_i;
    end
  end

  // Tick pulse and the tick index at which the current step ends.
  always_comb begin
    tick_s     = (tcnt_q == TICK_LAST);
    dur_last_s = (dur_q == {DUR_W{1'b0}}) ? {DUR_W{1'b0}} : (dur_q - DUR_W'(1));
  end

  // Next-state and output logic. The FETCH state samples the table straight
  // into the output registers, so the table read is registered and reads old
  // data when a write to the same address lands in the same cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    freq_d     = freq_q;
    wave_d     = wave_q;
    duty_d     = duty_q;
    step_idx_d = step_idx_q;
    dur_d      = dur_q;
    tcnt_d     = tcnt_q;
    dcnt_d     = dcnt_q;
    strobe_d   = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (stop_i) begin
      state_d = ST_IDLE;
      freq_d  = 64'd0;
      wave_d  = 2'd0;
      duty_d  = {BIT_DEPTH{1'b0}};
      busy_d  = 1'b0;
      tcnt_d  = {TICK_W{1'b0}};
      dcnt_d  = {DUR_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE: begin
          freq_d = 64'd0;
          wave_d = 2'd0;
          duty_d = {BIT_DEPTH{1'b0}};
          if (start_i) begin
            last_d  = clamp_last(last_step_i);
            idx_d   = {ADDR_W{1'b0}};
            busy_d  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            busy_d = 1'b0;
          end
        end
        ST_FETCH: begin
          freq_d     = freq_mem[idx_q];
          wave_d     = wave_mem[idx_q];
          duty_d     = duty_mem[idx_q];
          dur_d      = dur_mem[idx_q];
          step_idx_d = idx_q;
          strobe_d   = 1'b1;
          tcnt_d     = {TICK_W{1'b0}};
          dcnt_d     = {DUR_W{1'b0}};
          state_d    = ST_PLAY;
        end
        ST_PLAY: begin
          if (tick_s) begin
            tcnt_d = {TICK_W{1'b0}};
            if (dcnt_q == dur_last_s) begin
              dcnt_d = {DUR_W{1'b0}};
              if (idx_q != last_q) begin
                idx_d   = idx_q + ADDR_W'(1);
                state_d = ST_FETCH;
              end else if (loop_i) begin
                idx_d   = {ADDR_W{1'b0}};
                state_d = ST_FETCH;
              end else begin
                state_d = ST_IDLE;
                freq_d  = 64'd0;
                wave_d  = 2'd0;
                duty_d  = {BIT_DEPTH{1'b0}};
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            end else begin
              dcnt_d = dcnt_q + DUR_W'(1);
            end
          end else begin
            tcnt_d = tcnt_q + TICK_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          freq_d  = 64'd0;
          wave_d  = 2'd0;
          duty_d  = {BIT_DEPTH{1'b0}};
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= {ADDR_W{1'b0}};
      last_q     <= {ADDR_W{1'b0}};
      freq_q     <= 64'd0;
      wave_q     <= 2'd0;
      duty_q     <= {BIT_DEPTH{1'b0}};
      step_idx_q <= {ADDR_W{1'b0}};
      dur_q      <= {DUR_W{1'b0}};
      tcnt_q     <= {TICK_W{1'b0}};
      dcnt_q     <= {DUR_W{1'b0}};
      strobe_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      freq_q     <= freq_d;
      wave_q     <= wave_d;
      duty_q     <= duty_d;
      step_idx_q <= step_idx_d;
      dur_q      <= dur_d;
      tcnt_q     <= tcnt_d;
      dcnt_q     <= dcnt_d;
      strobe_q   <= strobe_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign frequency_o   = freq_q;
  assign wave_o        = wave_q;
  assign duty_cycle_o  = duty_q;
  assign step_idx_o    = step_idx_q;
  assign step_strobe_o = strobe_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
